seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the generating end of the single-bit serial input that feeds the team's Moore sequence detectors.
- On start, latches a PAT_W-bit pattern and shifts it out MSB-first on dout, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between frames.
- Serves as the stimulus source for detector blocks and as a simple serial framing transmitter.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat count input
GAP_W, 3, width of inter-frame gap length input

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request to begin transmission; sampled only in IDLE
pattern  input  PAT_W  pattern to send, latched at start acceptance
repeat_cnt  input  CNT_W  number of frames; 0 treated as 1
gap_len  input  GAP_W  idle bit-cycles between frames; 0 = back-to-back
dout  output  1  serial data, registered
bit_valid  output  1  high while dout carries a pattern bit
busy  output  1  high from cycle after start acceptance until done
frame_done  output  1  one-cycle pulse coincident with last bit of each frame
done  output  1  one-cycle pulse after last frame's last bit

Behaviour:
- Reset (rst=0, async): state IDLE; dout, bit_valid, busy, frame_done, done = 0; shift register, bit counter, frame counter and gap counter = 0.
- Release of rst takes effect at the next clk edge. Reset mid-transmission aborts immediately: no done pulse, dout returns to 0.
- All outputs are registered (Moore). No output depends combinationally on start or the data inputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - dout=0, busy=0.
  - start=1 at edge k: latch pattern, repeat_cnt (0 becomes 1) and gap_len; go to SHIFT.
  - busy=1 from cycle k+1.
- SHIFT:
  - Cycle k+1+i (i=0..PAT_W-1): dout=pattern[PAT_W-1-i], bit_valid=1.
  - On the last bit: frame_done=1 and the frame counter decrements.
  - If frames remain and gap_len>0: go to GAP.
  - If frames remain and gap_len=0: stay in SHIFT with the bit counter reloaded; the next frame's MSB follows immediately with no dead cycle.
  - If no frames remain: go to DONE.
- GAP: dout=0, bit_valid=0 for exactly gap_len cycles, then SHIFT.
- DONE:
  - Exactly one cycle: done=1, busy=0, dout=0, bit_valid=0.
  - Then IDLE.
  - start is ignored in DONE; the earliest new acceptance is in the IDLE cycle after DONE.
- start asserted while busy (SHIFT, GAP, DONE) is ignored and does not queue.
- pattern, repeat_cnt and gap_len changes after acceptance have no effect on the frame in flight.
- Timing: total busy cycles = PAT_W*N + gap_len*(N-1), where N = effective repeat count. done occurs the cycle after the last bit.
- Counters:
  - Bit counter: ceil(log2(PAT_W)) bits, counts down and wraps by reload only.
  - Frame counter: CNT_W bits.
  - Gap counter: GAP_W bits.
  - No counter may underflow. The terminal-count compare is against 1, not 0 wrap.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum type (IDLE, SHIFT, GAP, DONE; 2-bit encoding 00, 01, 10, 11);
  - the localparam for bit-counter width, derived from PAT_W.
- One natural sub-module: load_down_counter.
  - Parameterised width, with load, enable and terminal-count (==1) outputs.
  - Instantiated three times: bit, frame and gap counters.
- The FSM and shift register stay in seq_pattern_tx.

Test Plan:
- Single frame: PAT_W=4, pattern=4'b1011, repeat_cnt=1, gap_len=0, start pulse at cycle 0 -> dout=1,0,1,1 on cycles 1-4 with bit_valid=1; frame_done on cycle 4; done on cycle 5; busy high on cycles 1-4.
- Repeat with gap: pattern=4'b1111, repeat_cnt=3, gap_len=2 -> bits on cycles 1-4, 7-10, 13-16; dout=0 and bit_valid=0 on cycles 5-6 and 11-12; three frame_done pulses; done on cycle 17.
- Back-to-back into detector: pattern=4'b1111, repeat_cnt=2, gap_len=0, dout wired to the 4-ones Moore detector's din -> 8 contiguous ones on cycles 1-8; detector dout checked against its own spec; done on cycle 9.
- repeat_cnt=0 and start held high throughout -> exactly one frame sent; start ignored while busy and in DONE; second acceptance in the IDLE cycle after DONE.
- Reset mid-frame: rst=0 asynchronously during the 3rd bit -> dout, busy, bit_valid = 0 immediately; no done pulse; after release, new start behaves as in the single-frame scenario.
- PAT_W=8, pattern=8'hA5, repeat_cnt=1 -> dout=1,0,1,0,0,1,0,1 on cycles 1-8; done on cycle 9.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and counter sizing for the serial pattern transmitter
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, GAP = 2'b10, DONE = 2'b11} state_e;
  localparam int DEF_PAT_W = 4;
  localparam int DEF_BCNT_W = $clog2(DEF_PAT_W);
  function automatic int bcnt_w(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control inputs and serial outputs of the pattern transmitter
interface seq_pattern_tx_if #(parameter int PAT_W = 4, parameter int CNT_W = 4, parameter int GAP_W = 3);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             dout;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;
  logic             done;
  modport master (output start, pattern, repeat_cnt, gap_len, input dout, bit_valid, busy, frame_done, done);
  modport slave (input start, pattern, repeat_cnt, gap_len, output dout, bit_valid, busy, frame_done, done);
endinterface

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter that holds at zero and flags a count of one
module load_down_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == W'(1);
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: shifts a latched pattern out MSB-first, repeated N times with optional idle gaps
module seq_pattern_tx import seq_pkg::*; #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);
  localparam int BW = bcnt_w(PAT_W);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, shreg_q, shreg_d, src;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic             dout_q, dout_d, bit_valid_q, bit_valid_d, busy_q, busy_d;
  logic             frame_done_q, frame_done_d, done_q, done_d;
  logic             b_load, b_en, b_tc, f_load, f_en, f_tc, g_load, g_en, g_tc;
  logic [CNT_W-1:0] n_eff;
  assign n_eff = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
  assign src = (state_q == IDLE) ? bus.pattern : pat_q;
  load_down_counter #(.W(BW)) u_bit (.clk(clk), .rst(rst), .load_i(b_load), .val_i(BW'(PAT_W - 1)), .en_i(b_en), .tc_o(b_tc));
  load_down_counter #(.W(CNT_W)) u_frame (.clk(clk), .rst(rst), .load_i(f_load), .val_i(n_eff), .en_i(f_en), .tc_o(f_tc));
  load_down_counter #(.W(GAP_W)) u_gap (.clk(clk), .rst(rst), .load_i(g_load), .val_i(gap_len_q), .en_i(g_en), .tc_o(g_tc));
  // frame_done_q doubles as "the bit on dout now is the frame's last one"
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    gap_len_d = gap_len_q;
    shreg_d = shreg_q;
    dout_d = 1'b0;
    bit_valid_d = 1'b0;
    frame_done_d = 1'b0;
    done_d = 1'b0;
    b_load = 1'b0;
    b_en = 1'b0;
    f_load = 1'b0;
    f_en = 1'b0;
    g_load = 1'b0;
    g_en = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        pat_d = bus.pattern;
        gap_len_d = bus.gap_len;
        f_load = 1'b1;
        b_load = 1'b1;
      end
      SHIFT: if (!frame_done_q) begin
        b_en = 1'b1;
        dout_d = shreg_q[PAT_W-1];
        shreg_d = shreg_q << 1;
        bit_valid_d = 1'b1;
        frame_done_d = b_tc;
      end else begin
        f_en = 1'b1;
        if (f_tc) begin
          state_d = DONE;
          done_d = 1'b1;
        end else if (gap_len_q != '0) begin
          state_d = GAP;
          g_load = 1'b1;
        end else b_load = 1'b1;
      end
      GAP: begin
        g_en = 1'b1;
        if (g_tc) begin
          state_d = SHIFT;
          b_load = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (b_load) begin
      dout_d = src[PAT_W-1];
      shreg_d = src << 1;
      bit_valid_d = 1'b1;
    end
    busy_d = (state_d == SHIFT) || (state_d == GAP);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      shreg_q <= '0;
      gap_len_q <= '0;
      dout_q <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      shreg_q <= shreg_d;
      gap_len_q <= gap_len_d;
      dout_q <= dout_d;
      bit_valid_q <= bit_valid_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      done_q <= done_d;
    end
  assign bus.dout = dout_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.busy = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.done = done_q;
endmodule
